// File: rtl/i2c_target_model.sv
`timescale 1ns/1ps
// i2c_target_model
// Simulation-oriented I2C target that answers a single 7-bit address and
// exposes a small byte register file behind an auto-incrementing pointer.
// The first byte written after the address sets the pointer. Every later
// written byte is stored at the pointer, and the pointer then advances.
// Reads return reg[ptr], and the pointer advances on each byte.
//
// Ports
//   clk_i        system clock (same clock as the I2C host)
//   rst_i        asynchronous, active-high reset
//   scl_i        resolved SCL bus level
//   sda_i        resolved SDA bus level
//   sda_oe_o     1 pulls SDA low, 0 releases it (registered)
//   busy_o       high from an address match until STOP, START or reset
//   reg_wr_o     one-cycle pulse on each register write
//   reg_addr_o   register index of the write
//   reg_wdata_o  data byte of the write
//   dbg_state_o  current FSM state, for checkers and debug
//
// Handshake: this block has no valid/ready channels. reg_wr_o is a one-cycle
// strobe. reg_addr_o and reg_wdata_o are valid in the cycle where reg_wr_o is
// high and hold their value until the next write. There is no back-pressure.
module i2c_target_model #(
  parameter logic [6:0] Addr    = 7'h50,
  parameter int         NumRegs = 16,
  localparam int        PW      = $clog2(NumRegs)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe_o,
  output logic          busy_o,
  output logic          reg_wr_o,
  output logic [PW-1:0] reg_addr_o,
  output logic [7:0]    reg_wdata_o,
  output logic [3:0]    dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t        state;
  logic [7:0]    regs [NumRegs];
  logic [PW-1:0] ptr;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          rw;
  // In the ACK states, this is set after the SCL fall that begins the ACK bit.
  // In RDATA_ACK, it is set after the host has ACKed and the next byte is
  // waiting for the SCL fall.
  logic          ack_on;

  // Two-flop synchronizers followed by one history flop per line.
  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  logic [7:0]    byte_in;
  logic          last_bit;
  logic [PW-1:0] ptr_inc;
  assign byte_in  = {shift[6:0], sda_sync};
  assign last_bit = (bit_cnt == 3'd7);
  assign ptr_inc  = ptr + PW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      rw          <= 1'b0;
      ack_on      <= 1'b0;
      sda_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      reg_wr_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= 8'(i);
      end
    end else begin
      reg_wr_o <= 1'b0;
      // Bus conditions take precedence over any SCL edge in the same cycle.
      // A partly shifted byte is discarded because only the 8th bit commits.
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        ack_on   <= 1'b0;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        ack_on   <= 1'b0;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (byte_in[7:1] == Addr) begin
                  busy_o <= 1'b1;
                  rw     <= byte_in[0];
                  state  <= ADDR_ACK;
                end else begin
                  state  <= IDLE;
                end
              end
            end
          end

          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe_o <= 1'b1;
                ack_on   <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  shift    <= regs[ptr];
                  sda_oe_o <= ~regs[ptr][7];
                  state    <= RDATA;
                end else begin
                  sda_oe_o <= 1'b0;
                  state    <= (state == ADDR_ACK) ? PTR : WDATA;
                end
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                ptr   <= byte_in[PW-1:0];
                state <= PTR_ACK;
              end
            end
          end

          WDATA: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                regs[ptr]   <= byte_in;
                reg_wr_o    <= 1'b1;
                reg_addr_o  <= ptr;
                reg_wdata_o <= byte_in;
                ptr         <= ptr_inc;
                state       <= WDATA_ACK;
              end
            end
          end

          // Bit 7 is already driven on entry. Each SCL fall then presents the
          // next lower bit, and the 8th fall releases SDA for the host ACK.
          RDATA: begin
            if (scl_fall) begin
              if (last_bit) begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= '0;
                state    <= RDATA_ACK;
              end else begin
                sda_oe_o <= ~shift[6];
                shift    <= {shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end

          RDATA_ACK: begin
            if (scl_rise && !ack_on) begin
              ptr <= ptr_inc;
              if (!sda_sync) begin
                shift  <= regs[ptr_inc];
                ack_on <= 1'b1;
              end else begin
                state  <= IDLE;
              end
            end else if (scl_fall && ack_on) begin
              ack_on   <= 1'b0;
              sda_oe_o <= ~shift[7];
              bit_cnt  <= '0;
              state    <= RDATA;
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_i2c_target_model.sv
`timescale 1ns/1ps
module tb_i2c_target_model;

  localparam int NREG = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_scl = 1'b1;
  logic       host_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe, busy, reg_wr;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [3:0] dbg_state;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus = host_sda & ~sda_oe;

  i2c_target_model #(.Addr(7'h50), .NumRegs(NREG)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (host_scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe),
    .busy_o     (busy),
    .reg_wr_o   (reg_wr),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish within 3ms");
    $fatal(1, "watchdog");
  end

  // ---------------- counters, monitors ----------------
  int checks = 0;
  int failures = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int oe_bad = 0;
  logic oe_prev = 1'b0;
  logic [11:0] wr_obs_q[$];
  logic [11:0] exp_q[$];
  int wr_idx = 0;

  always @(negedge clk) begin
    if (reg_wr) wr_obs_q.push_back({reg_addr, reg_wdata});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (!rst && host_scl && (sda_oe !== oe_prev)) oe_bad++;
    oe_prev = sda_oe;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_regs [NREG];
  int m_ptr;

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'(i);
    m_ptr = 0;
    exp_q.delete();
    wr_idx = wr_obs_q.size();
  endtask

  task automatic m_set_ptr(input logic [7:0] b);
    m_ptr = int'(b) % NREG;
  endtask

  task automatic m_write(input logic [7:0] b);
    m_regs[m_ptr] = b;
    exp_q.push_back({4'(m_ptr), b});
    m_ptr = (m_ptr + 1) % NREG;
  endtask

  task automatic m_read(output logic [7:0] b);
    b = m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % NREG;
  endtask

  // ---------------- bus driver tasks ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    host_sda = 1'b1; wait_n(5);
    host_scl = 1'b1; wait_n(5);
    host_sda = 1'b0; wait_n(5);
    host_scl = 1'b0; wait_n(5);
  endtask

  task automatic bus_stop();
    host_sda = 1'b0; wait_n(5);
    host_scl = 1'b1; wait_n(5);
    host_sda = 1'b1; wait_n(5);
  endtask

  task automatic send_bit(input logic b);
    host_sda = b;    wait_n(5);
    host_scl = 1'b1; wait_n(10);
    host_scl = 1'b0; wait_n(5);
  endtask

  task automatic recv_bit(output logic b);
    host_sda = 1'b1; wait_n(5);
    host_scl = 1'b1; wait_n(5);
    b = sda_bus;     wait_n(5);
    host_scl = 1'b0; wait_n(5);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic oe_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    host_sda = nack; wait_n(5);
    host_scl = 1'b1; wait_n(5);
    oe_ack = sda_oe; wait_n(5);
    host_scl = 1'b0; wait_n(5);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    wait_n(3);
    checks++;
    if (sda_oe !== 1'b0) begin
      failures++; $display("FAIL reset_oe_during: got %b want 0", sda_oe);
    end
    rst = 1'b0;
    wait_n(3);
    m_reset();
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b want 0", sda_oe); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (reg_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b want 0", reg_wr); end
    checks++;
    if (reg_addr !== 4'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", reg_addr); end
    checks++;
    if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
  endtask

  task automatic test_write_wrap();
    logic ack, oe_ack;
    logic [7:0] d, e;
    logic [7:0] bytes [4];
    logic [11:0] ew;
    bytes[0] = 8'hA0; bytes[1] = 8'h0F; bytes[2] = 8'hDE; bytes[3] = 8'hAD;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      if (i == 1) m_set_ptr(bytes[i]);
      if (i >= 2) m_write(bytes[i]);
      checks++;
      if (ack !== 1'b1) begin failures++; $display("FAIL wrap_ack%0d: got %b want 1", i, ack); end
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL wrap_busy: got %b want 1", busy); end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_stop: got %b want 0", busy); end
    checks++;
    if (wr_obs_q.size() !== wr_idx + exp_q.size()) begin
      failures++; $display("FAIL wrap_wr_count: got %0d want %0d", wr_obs_q.size() - wr_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      if (wr_idx < wr_obs_q.size()) begin
        checks++;
        if (wr_obs_q[wr_idx] !== ew) begin
          failures++; $display("FAIL wrap_wr: got %h want %h", wr_obs_q[wr_idx], ew);
        end
      end
      wr_idx++;
    end
    wr_idx = wr_obs_q.size();
    // Pointer should now sit at 1: read from the current pointer.
    bus_start();
    write_byte(8'hA1, ack);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL wrap_rd_ack: got %b want 1", ack); end
    read_byte(1'b1, d, oe_ack);
    m_read(e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL wrap_ptr_read: got %h want %h", d, e); end
    bus_stop();
  endtask

  task automatic test_read_after_reset();
    logic ack, oe_ack;
    logic [7:0] d, e;
    rst = 1'b1; wait_n(3); rst = 1'b0; wait_n(3);
    m_reset();
    bus_start();
    write_byte(8'hA0, ack);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
    write_byte(8'h0E, ack);
    m_set_ptr(8'h0E);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL rd_ptr_ack: got %b want 1", ack); end
    bus_start();
    write_byte(8'hA1, ack);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL rd_addr2_ack: got %b want 1", ack); end
    for (int i = 0; i < 3; i++) begin
      read_byte(i == 2, d, oe_ack);
      m_read(e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL rd_data%0d: got %h want %h", i, d, e); end
    end
    checks++;
    if (oe_ack !== 1'b0) begin failures++; $display("FAIL rd_nack_release: got %b want 0", oe_ack); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy_after_nack: got %b want 1", busy); end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
    checks++;
    if (wr_obs_q.size() !== wr_idx) begin
      failures++; $display("FAIL rd_no_write: got %0d writes want 0", wr_obs_q.size() - wr_idx);
    end
    wr_idx = wr_obs_q.size();
  endtask

  task automatic test_mismatch();
    logic ack;
    int oe0, busy0;
    oe0 = oe_cnt; busy0 = busy_cnt;
    bus_start();
    write_byte(8'hA2, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL mis_addr_ack: got %b want 0", ack); end
    write_byte(8'h05, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL mis_data_ack: got %b want 0", ack); end
    bus_stop();
    checks++;
    if (oe_cnt !== oe0) begin failures++; $display("FAIL mis_oe: got %0d cycles want 0", oe_cnt - oe0); end
    checks++;
    if (busy_cnt !== busy0) begin failures++; $display("FAIL mis_busy: got %0d cycles want 0", busy_cnt - busy0); end
    checks++;
    if (wr_obs_q.size() !== wr_idx) begin
      failures++; $display("FAIL mis_no_write: got %0d writes want 0", wr_obs_q.size() - wr_idx);
    end
    wr_idx = wr_obs_q.size();
  endtask

  task automatic test_aborted_write();
    logic ack, oe_ack;
    logic [7:0] d, e;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    m_set_ptr(8'h02);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_stop();
    checks++;
    if (wr_obs_q.size() !== wr_idx) begin
      failures++; $display("FAIL abort_no_write: got %0d writes want 0", wr_obs_q.size() - wr_idx);
    end
    wr_idx = wr_obs_q.size();
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    m_set_ptr(8'h02);
    bus_start();
    write_byte(8'hA1, ack);
    read_byte(1'b1, d, oe_ack);
    m_read(e);
    bus_stop();
    checks++;
    if (d !== e) begin failures++; $display("FAIL abort_readback: got %h want %h", d, e); end
  endtask

  task automatic test_ptr_trunc();
    logic ack;
    logic [11:0] got;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h13, ack);
    m_set_ptr(8'h13);
    write_byte(8'h77, ack);
    m_write(8'h77);
    bus_stop();
    checks++;
    if (wr_obs_q.size() !== wr_idx + 1) begin
      failures++; $display("FAIL trunc_wr_count: got %0d want 1", wr_obs_q.size() - wr_idx);
    end else begin
      got = wr_obs_q[wr_idx];
      checks++;
      if (got !== exp_q[0]) begin failures++; $display("FAIL trunc_wr: got %h want %h", got, exp_q[0]); end
    end
    exp_q.delete();
    wr_idx = wr_obs_q.size();
  endtask

  task automatic test_random();
    logic ack, oe_ack, rw;
    logic [7:0] d, e, p;
    logic [6:0] a7;
    logic [11:0] ew;
    int kind, n, oe0;
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      if (kind == 3) begin
        a7 = 7'h50 ^ (7'd1 << $urandom_range(0, 6));
        rw = 1'($urandom_range(0, 1));
        oe0 = oe_cnt;
        bus_start();
        write_byte({a7, rw}, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL rnd_mis_ack t%0d: got %b want 0", t, ack); end
        write_byte(8'($urandom), ack);
        bus_stop();
        checks++;
        if (oe_cnt !== oe0) begin failures++; $display("FAIL rnd_mis_oe t%0d: got %0d cycles want 0", t, oe_cnt - oe0); end
      end else begin
        bus_start();
        if (kind != 2) begin
          write_byte(8'hA0, ack);
          p = 8'($urandom_range(0, 255));
          write_byte(p, ack);
          m_set_ptr(p);
          checks++;
          if (ack !== 1'b1) begin failures++; $display("FAIL rnd_ptr_ack t%0d: got %b want 1", t, ack); end
        end
        if (kind == 0) begin
          for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            write_byte(d, ack);
            m_write(d);
            checks++;
            if (ack !== 1'b1) begin failures++; $display("FAIL rnd_wr_ack t%0d: got %b want 1", t, ack); end
          end
        end else begin
          if (kind == 1) bus_start();
          write_byte(8'hA1, ack);
          checks++;
          if (ack !== 1'b1) begin failures++; $display("FAIL rnd_rd_ack t%0d: got %b want 1", t, ack); end
          for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d, oe_ack);
            m_read(e);
            checks++;
            if (d !== e) begin failures++; $display("FAIL rnd_rd t%0d b%0d: got %h want %h", t, i, d, e); end
          end
        end
        bus_stop();
      end
      checks++;
      if (wr_obs_q.size() !== wr_idx + exp_q.size()) begin
        failures++; $display("FAIL rnd_wr_count t%0d: got %0d want %0d", t, wr_obs_q.size() - wr_idx, exp_q.size());
      end
      while (exp_q.size() > 0) begin
        ew = exp_q.pop_front();
        if (wr_idx < wr_obs_q.size()) begin
          checks++;
          if (wr_obs_q[wr_idx] !== ew) begin
            failures++; $display("FAIL rnd_wr t%0d: got %h want %h", t, wr_obs_q[wr_idx], ew);
          end
        end
        wr_idx++;
      end
      wr_idx = wr_obs_q.size();
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack, oe_ack, seen;
    logic [7:0] d, e;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    m_set_ptr(8'h05);
    write_byte(8'h00, ack);
    m_write(8'h00);
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    m_set_ptr(8'h05);
    bus_start();
    write_byte(8'hA1, ack);
    // reg5 now holds 0x00, so the target pulls SDA low for bit 7.
    host_sda = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sda_oe === 1'b1) seen = 1'b1;
      else wait_n(1);
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL rst_mid_oe_high: got %b want 1", sda_oe); end
    host_scl = 1'b1;
    wait_n(3);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_async: got %b want 0", sda_oe); end
    host_sda = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(5);
    m_reset();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    m_set_ptr(8'h00);
    bus_start();
    write_byte(8'hA1, ack);
    read_byte(1'b1, d, oe_ack);
    m_read(e);
    bus_stop();
    checks++;
    if (d !== e) begin failures++; $display("FAIL rst_mid_readback: got %h want %h", d, e); end
  endtask

  task automatic test_oe_timing();
    checks++;
    if (oe_bad !== 0) begin
      failures++; $display("FAIL oe_change_scl_high: got %0d changes want 0", oe_bad);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_write_wrap();
    test_read_after_reset();
    test_mismatch();
    test_aborted_write();
    test_ptr_trunc();
    test_random();
    test_reset_mid_read();
    test_oe_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
